// File: rtl/trig_pkg.sv
// Shared definitions for the trigger event serializer: default sizing and index-width helper.
// Imported by the serializer top and its round-robin arbiter.
package trig_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    // An index bus is never narrower than one bit, even for a single source.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trig_event_serializer_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, wrapping.
// A double-width vector (masked copy below, full copy above) turns the wrap into one priority search.
module rr_arbiter
    import trig_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]              req_i,
    input  logic [clog2_min1(WIDTH)-1:0]  ptr_i,
    output logic                          grant_valid_o,
    output logic [clog2_min1(WIDTH)-1:0]  grant_idx_o
);

    localparam int IDX_W = clog2_min1(WIDTH);

    logic [WIDTH-1:0]   mask;
    logic [2*WIDTH-1:0] dbl_req;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        mask          = '0;
        dbl_req       = '0;
        grant_valid_o = |req_i;
        grant_idx_o   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i >= int'(ptr_i));
        end
        dbl_req = {req_i, req_i & mask};
        // Scanning downward lets the lowest set bit overwrite the result last.
        for (int i = 2 * WIDTH - 1; i >= 0; i--) begin
            if (dbl_req[i]) begin
                grant_idx_o = IDX_W'(i % WIDTH);
            end
        end
    end

endmodule

// File: rtl/trig_event_serializer.sv
// Per-source pending-event counters serialized into one valid/ready stream of source indices.
// Round-robin service; a sticky per-source flag records any event lost to counter saturation.
module trig_event_serializer
    import trig_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              trig_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [clog2_min1(WIDTH)-1:0]  out_idx,
    output logic                          busy,
    output logic [WIDTH-1:0]              overflow,
    input  logic                          clr_ovf
);

    localparam int IDX_W = clog2_min1(WIDTH);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    cnt_t             cnt_q [WIDTH];
    cnt_t             cnt_d [WIDTH];
    logic [WIDTH-1:0] overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] load_hit;
    logic [WIDTH-1:0] ovf_set;
    logic             load;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    // Arbitration sees only registered counts, so a same-edge trigger waits a cycle.
    always_comb begin
        req = '0;
        for (int i = 0; i < WIDTH; i++) begin
            req[i] = (cnt_q[i] != '0);
        end
    end

    assign load = ~out_valid_q | out_ready;

    rr_arbiter #(
        .WIDTH (WIDTH)
    ) u_arb (
        .req_i         (req),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // A load of source i frees a counter slot in the same edge, so it cannot overflow then.
    always_comb begin
        load_hit = '0;
        ovf_set  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]    = cnt_q[i];
            load_hit[i] = load && grant_valid && (grant_idx == IDX_W'(i));
            if (trig_in[i] && !load_hit[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!trig_in[i] && load_hit[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        overflow_d = (clr_ovf ? '0 : overflow_q) | ovf_set;
    end

    // Output slot and round-robin pointer; an idle load empties the slot but keeps the pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_idx_d = grant_idx;
                rr_ptr_d  = (grant_idx == IDX_W'(WIDTH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others. The counters are a
    // handful of flops rather than a RAM, so they are cleared like any register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            overflow_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign overflow  = overflow_q;
    assign busy      = out_valid_q | (|req);

endmodule
